game_sequencer: RTL and testbench

Top-level game-phase controller for the frogger-style VGA game. It sequences the player/car datapath through title, play, hit-pause, level-up-pause and game-over phases. It owns the life, level and car-speed registers and gates player and car movement. It sits between the collision/goal detection in player control, the car movers, the LEDs and the seven-segment driver.

---
 rtl/game_sequencer_pkg.sv | 38 +++
 rtl/game_sequencer_if.sv | 26 ++
 rtl/game_sequencer_bcd_level_counter.sv | 28 ++
 rtl/game_sequencer.sv | 136 +++++++++++++
 tb/tb_game_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the game sequencer: phase encodings, timing
// defaults and the seven-segment digit map used by both this block and
// player control.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_t;

    // 1 s pause and 4 Hz blink at 25 MHz.
    localparam int DEF_PAUSE_CYCLES = 25_000_000;
    localparam int DEF_FLASH_CYCLES = 6_250_000;
    localparam int DEF_SPEED_MAX    = 31;

    localparam logic [3:0] LIFE_FULL = 4'b1111;

    // Active-low segments {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Event inputs and registered status outputs of the game sequencer.
interface game_sequencer_if;
    logic       start;
    logic       collide;
    logic       reached_top;
    logic [2:0] state;
    logic       play_en;
    logic       respawn;
    logic [3:0] life;
    logic [3:0] units;
    logic [3:0] tens;
    logic [4:0] speed_car;
    logic       flash;

    // Environment side: drives events, observes the phase outputs.
    modport master (
        output start, collide, reached_top,
        input  state, play_en, respawn, life, units, tens, speed_car, flash
    );

    // Sequencer side.
    modport slave (
        input  start, collide, reached_top,
        output state, play_en, respawn, life, units, tens, speed_car, flash
    );
endinterface

// File: rtl/game_sequencer_bcd_level_counter.sv
// Two-digit BCD level counter, saturating at 99; clr wins over inc.
module bcd_level_counter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] units,
    output logic [3:0] tens
);

    // Decimal increment with carry into tens, holding at 99.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            units <= 4'd0;
            tens  <= 4'd0;
        end else if (inc) begin
            if (units == 4'd9) begin
                if (tens != 4'd9) begin
                    units <= 4'd0;
                    tens  <= tens + 4'd1;
                end
            end else begin
                units <= units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-phase controller: sequences title, play, hit/level-up pauses and
// game over; owns life, level and car-speed registers and gates motion.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int PAUSE_CYCLES = DEF_PAUSE_CYCLES,
    parameter int FLASH_CYCLES = DEF_FLASH_CYCLES,
    parameter int SPEED_MAX    = DEF_SPEED_MAX
) (
    input  logic              CLK,
    input  logic              RST,
    game_sequencer_if.slave   bus
);

    localparam int TW = $clog2(PAUSE_CYCLES + 1);
    localparam int FW = $clog2(FLASH_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(PAUSE_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);
    localparam logic [4:0]    SPEED_TOP  = 5'(SPEED_MAX);

    game_state_t   state_q, state_d;
    logic [3:0]    life_q, life_d;
    logic [4:0]    speed_q, speed_d;
    logic [TW-1:0] timer_q;
    logic [FW-1:0] fcnt_q;
    logic          start_q, start_rise;
    logic          timer_done;
    logic          lvl_inc, lvl_clr;
    logic          play_en_q, respawn_q, flash_q;
    logic          in_pause, flash_state, entering;

    assign start_rise  = bus.start & ~start_q;
    assign timer_done  = (timer_q == TIMER_LAST);
    assign entering    = (state_d != state_q);
    assign in_pause    = (state_q == ST_HIT) || (state_q == ST_LEVEL_UP) ||
                         (state_q == ST_GAME_OVER);
    assign flash_state = (state_d == ST_HIT) || (state_d == ST_GAME_OVER);

    // Next phase and the life/speed/level updates triggered by events.
    always_comb begin
        state_d = state_q;
        life_d  = life_q;
        speed_d = speed_q;
        lvl_inc = 1'b0;
        lvl_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // A hit outranks reaching the top in the same cycle.
                if (bus.collide) begin
                    life_d  = life_q >> 1;
                    state_d = (life_q == 4'b0001) ? ST_GAME_OVER : ST_HIT;
                end else if (bus.reached_top) begin
                    lvl_inc = 1'b1;
                    if (speed_q != SPEED_TOP) speed_d = speed_q + 5'd1;
                    state_d = ST_LEVEL_UP;
                end
            end
            ST_HIT, ST_LEVEL_UP: begin
                if (timer_done) state_d = ST_PLAY;
            end
            ST_GAME_OVER: begin
                // Restart only once the minimum game-over pause has elapsed.
                if (timer_done && start_rise) begin
                    state_d = ST_PLAY;
                    life_d  = LIFE_FULL;
                    speed_d = 5'd0;
                    lvl_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase register and registered decodes of the next phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            life_q    <= LIFE_FULL;
            speed_q   <= 5'd0;
            start_q   <= 1'b0;
            play_en_q <= 1'b0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            life_q    <= life_d;
            speed_q   <= speed_d;
            start_q   <= bus.start;
            play_en_q <= (state_d == ST_PLAY);
            respawn_q <= (state_d == ST_PLAY) && (state_q != ST_PLAY);
        end
    end

    // Pause timer: cleared on every phase change, counts up and holds at the end.
    always_ff @(posedge CLK) begin
        if (RST || entering)
            timer_q <= '0;
        else if (in_pause && !timer_done)
            timer_q <= timer_q + 1'b1;
    end

    // Blink: starts lit on entry to HIT/GAME_OVER, toggles each FLASH_CYCLES.
    always_ff @(posedge CLK) begin
        if (RST || !flash_state) begin
            flash_q <= 1'b0;
            fcnt_q  <= '0;
        end else if (entering) begin
            flash_q <= 1'b1;
            fcnt_q  <= '0;
        end else if (fcnt_q == FLASH_LAST) begin
            flash_q <= ~flash_q;
            fcnt_q  <= '0;
        end else begin
            fcnt_q  <= fcnt_q + 1'b1;
        end
    end

    bcd_level_counter u_level (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (lvl_inc),
        .clr   (lvl_clr),
        .units (bus.units),
        .tens  (bus.tens)
    );

    assign bus.state     = state_q;
    assign bus.play_en   = play_en_q;
    assign bus.respawn   = respawn_q;
    assign bus.life      = life_q;
    assign bus.speed_car = speed_q;
    assign bus.flash     = flash_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short pauses (4 cycles, blink 2).
module tb_game_sequencer;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    game_sequencer_if bus ();

    game_sequencer #(
        .PAUSE_CYCLES (4),
        .FLASH_CYCLES (2),
        .SPEED_MAX    (31)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.collide = 0; bus.reached_top = 0;
        RST = 1;
        step(); step();
        total++;
        if ({bus.state, bus.play_en, bus.respawn, bus.life, bus.units, bus.tens, bus.speed_car, bus.flash}
            !== {3'd0, 1'b0, 1'b0, 4'b1111, 4'd0, 4'd0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset: state=%0d play_en=%0b respawn=%0b life=%b units=%0d tens=%0d speed=%0d flash=%0b, need 0 0 0 1111 0 0 0 0",
                     bus.state, bus.play_en, bus.respawn, bus.life, bus.units, bus.tens, bus.speed_car, bus.flash);
        end
        RST = 0;
        step();
        total++;
        if (bus.state !== 3'd0) begin bad++; $display("FAIL idle_hold: state=%0d need 0", bus.state); end
    endtask

    task automatic test_start();
        bus.start = 1;
        step();
        bus.start = 0;
        total++;
        if ({bus.state, bus.respawn, bus.play_en, bus.life} !== {3'd1, 1'b1, 1'b1, 4'b1111}) begin
            bad++;
            $display("FAIL start: state=%0d respawn=%0b play_en=%0b life=%b need 1 1 1 1111",
                     bus.state, bus.respawn, bus.play_en, bus.life);
        end
        step();
        total++;
        if ({bus.state, bus.respawn, bus.play_en} !== {3'd1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL respawn_once: state=%0d respawn=%0b play_en=%0b need 1 0 1",
                     bus.state, bus.respawn, bus.play_en);
        end
    endtask

    task automatic test_hit();
        bus.collide = 1;
        step();
        bus.collide = 0;
        total++;
        if ({bus.state, bus.life, bus.play_en, bus.flash} !== {3'd2, 4'b0111, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL hit_entry: state=%0d life=%b play_en=%0b flash=%0b need 2 0111 0 1",
                     bus.state, bus.life, bus.play_en, bus.flash);
        end
        step(); step();
        total++;
        if ({bus.state, bus.flash} !== {3'd2, 1'b0}) begin
            bad++;
            $display("FAIL hit_flash: state=%0d flash=%0b need 2 0", bus.state, bus.flash);
        end
        step();
        total++;
        if (bus.state !== 3'd2) begin bad++; $display("FAIL hit_hold: state=%0d need 2", bus.state); end
        step();
        total++;
        if ({bus.state, bus.respawn, bus.play_en, bus.flash} !== {3'd1, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL hit_exit: state=%0d respawn=%0b play_en=%0b flash=%0b need 1 1 1 0",
                     bus.state, bus.respawn, bus.play_en, bus.flash);
        end
    endtask

    task automatic test_game_over();
        logic [3:0] exp_life;
        exp_life = 4'b0111;
        for (int i = 0; i < 2; i++) begin
            bus.collide = 1;
            step();
            bus.collide = 0;
            exp_life = exp_life >> 1;
            total++;
            if ({bus.state, bus.life} !== {3'd2, exp_life}) begin
                bad++;
                $display("FAIL hit_%0d: state=%0d life=%b need 2 %b", i, bus.state, bus.life, exp_life);
            end
            repeat (4) step();
        end
        bus.collide = 1;
        step();
        bus.collide = 0;
        total++;
        if ({bus.state, bus.life, bus.flash, bus.play_en} !== {3'd4, 4'b0000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL gameover_entry: state=%0d life=%b flash=%0b play_en=%0b need 4 0000 1 0",
                     bus.state, bus.life, bus.flash, bus.play_en);
        end
        // Early start rise must be ignored.
        bus.start = 1;
        step();
        bus.start = 0;
        step(); step();
        total++;
        if ({bus.state, bus.respawn} !== {3'd4, 1'b0}) begin
            bad++;
            $display("FAIL gameover_early_start: state=%0d respawn=%0b need 4 0", bus.state, bus.respawn);
        end
        bus.start = 1;
        step();
        bus.start = 0;
        total++;
        if ({bus.state, bus.respawn, bus.life, bus.units, bus.tens, bus.speed_car} !==
            {3'd1, 1'b1, 4'b1111, 4'd0, 4'd0, 5'd0}) begin
            bad++;
            $display("FAIL gameover_restart: state=%0d respawn=%0b life=%b units=%0d tens=%0d speed=%0d need 1 1 1111 0 0 0",
                     bus.state, bus.respawn, bus.life, bus.units, bus.tens, bus.speed_car);
        end
    endtask

    task automatic test_level();
        for (int n = 1; n <= 100; n++) begin
            bus.reached_top = 1;
            step();
            bus.reached_top = 0;
            if (n == 1) begin
                total++;
                if ({bus.state, bus.units, bus.speed_car} !== {3'd3, 4'd1, 5'd1}) begin
                    bad++;
                    $display("FAIL level_first: state=%0d units=%0d speed=%0d need 3 1 1",
                             bus.state, bus.units, bus.speed_car);
                end
            end
            if (n == 9 || n == 10 || n == 99 || n == 100) begin
                total++;
                if ({bus.tens, bus.units, bus.speed_car} !==
                    {(n == 9) ? 4'd0 : (n == 10) ? 4'd1 : 4'd9,
                     (n == 9) ? 4'd9 : (n == 10) ? 4'd0 : 4'd9,
                     (n == 9) ? 5'd9 : (n == 10) ? 5'd10 : 5'd31}) begin
                    bad++;
                    $display("FAIL level_%0d: tens=%0d units=%0d speed=%0d", n, bus.tens, bus.units, bus.speed_car);
                end
            end
            repeat (4) step();
        end
        total++;
        if ({bus.state, bus.tens, bus.units} !== {3'd1, 4'd9, 4'd9}) begin
            bad++;
            $display("FAIL level_sat_play: state=%0d tens=%0d units=%0d need 1 9 9", bus.state, bus.tens, bus.units);
        end
    endtask

    task automatic test_both();
        bus.collide = 1;
        bus.reached_top = 1;
        step();
        bus.collide = 0;
        bus.reached_top = 0;
        total++;
        if ({bus.state, bus.life, bus.tens, bus.units, bus.speed_car} !==
            {3'd2, 4'b0111, 4'd9, 4'd9, 5'd31}) begin
            bad++;
            $display("FAIL collide_priority: state=%0d life=%b tens=%0d units=%0d speed=%0d need 2 0111 9 9 31",
                     bus.state, bus.life, bus.tens, bus.units, bus.speed_car);
        end
        repeat (4) step();
    endtask

    task automatic test_reset_mid_pause();
        bus.reached_top = 1;
        step();
        bus.reached_top = 0;
        step(); step();
        RST = 1;
        bus.start = 1;
        step();
        total++;
        if ({bus.state, bus.play_en, bus.respawn, bus.life, bus.units, bus.tens, bus.speed_car, bus.flash}
            !== {3'd0, 1'b0, 1'b0, 4'b1111, 4'd0, 4'd0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_pause: state=%0d play_en=%0b respawn=%0b life=%b units=%0d tens=%0d speed=%0d flash=%0b",
                     bus.state, bus.play_en, bus.respawn, bus.life, bus.units, bus.tens, bus.speed_car, bus.flash);
        end
        step();
        RST = 0;
        step();
        total++;
        if ({bus.state, bus.respawn} !== {3'd1, 1'b1}) begin
            bad++;
            $display("FAIL held_start_rise: state=%0d respawn=%0b need 1 1", bus.state, bus.respawn);
        end
        step();
        total++;
        if ({bus.state, bus.respawn} !== {3'd1, 1'b0}) begin
            bad++;
            $display("FAIL held_start_once: state=%0d respawn=%0b need 1 0", bus.state, bus.respawn);
        end
        bus.start = 0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_game_over();
        test_level();
        test_both();
        test_reset_mid_pause();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
